// File: rtl/div_ratio_controller.sv
// Run-time configurable clock-divide controller: owns the divide counter and
// terminal count, and swaps in new ratios only on a period boundary so no runt
// or stretched tick/div_out period is ever produced.
module div_ratio_controller #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_MAX = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_max,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             tick,
  output logic             div_out,
  output logic [CNT_W-1:0] cur_max,
  output logic             cfg_pending
);

  localparam logic [CNT_W-1:0] RST_MAX = CNT_W'(DEFAULT_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] cur_max_q,  cur_max_d;
  logic [CNT_W-1:0] pend_max_q, pend_max_d;
  logic             tick_q,     tick_d;
  logic             div_q,      div_d;
  logic             ready_q,    ready_d;
  logic             pending_q,  pending_d;

  logic cfg_acc;
  logic terminal;

  assign cfg_acc  = cfg_valid && ready_q;
  assign terminal = (cnt_q == cur_max_q);

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_max_d  = cur_max_q;
    pend_max_d = pend_max_q;
    tick_d     = 1'b0;
    div_d      = div_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_acc) begin
          cur_max_d = cfg_max;
          cnt_d     = '0;
        end
        if (enable) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!enable) begin
          // Disabled: no tick even if terminal was reached; a config arriving
          // now lands directly since there is no running period to protect.
          state_d = S_IDLE;
          if (cfg_acc) begin
            cur_max_d = cfg_max;
            cnt_d     = '0;
          end
        end else begin
          if (terminal) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            div_d  = ~div_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (cfg_acc) begin
            pend_max_d = cfg_max;
            state_d    = S_PEND;
          end
        end
      end

      S_PEND: begin
        if (!enable) begin
          state_d   = S_IDLE;
          cur_max_d = pend_max_q;
          cnt_d     = '0;
        end else if (terminal) begin
          cnt_d     = '0;
          tick_d    = 1'b1;
          div_d     = ~div_q;
          cur_max_d = pend_max_q;
          state_d   = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d   = (state_d != S_PEND);
    pending_d = (state_d == S_PEND);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_max_q  <= RST_MAX;
      pend_max_q <= '0;
      tick_q     <= 1'b0;
      div_q      <= 1'b0;
      ready_q    <= 1'b1;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_max_q  <= cur_max_d;
      pend_max_q <= pend_max_d;
      tick_q     <= tick_d;
      div_q      <= div_d;
      ready_q    <= ready_d;
      pending_q  <= pending_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign tick        = tick_q;
  assign div_out     = div_q;
  assign cur_max     = cur_max_q;
  assign cfg_pending = pending_q;

endmodule

// File: tb/tb_div_ratio_controller.sv
// Bench for div_ratio_controller: directed steps push expected tick cycles to a
// scoreboard queue; a negedge monitor pops and compares them as ticks appear.
module tb_div_ratio_controller;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [CNT_W-1:0] cfg_max;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             tick;
  logic             div_out;
  logic [CNT_W-1:0] cur_max;
  logic             cfg_pending;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int cyc      = 0;
  int exp_q[$];
  logic prev_div = 1'b0;

  div_ratio_controller #(.CNT_W(CNT_W), .DEFAULT_MAX(1)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .cfg_max(cfg_max),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .tick(tick),
    .div_out(div_out),
    .cur_max(cur_max),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ticks(input int first, input int step, input int last);
    for (int t = first; t <= last; t += step) exp_q.push_back(t);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic apply_cfg(input logic [CNT_W-1:0] v);
    cfg_max   = v;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Tick scoreboard and div_out toggle/hold monitor.
  always @(negedge clk) begin
    int e;
    if (rst) begin
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_div", 32'(div_out), 32'd0);
      prev_div = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        e = exp_q.pop_front();
        check("tick_missed", 32'(cyc), 32'(e));
      end
      if (tick) begin
        if (exp_q.size() == 0) begin
          check("tick_unexpected", 32'(tick), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("tick_cycle", 32'(cyc), 32'(e));
        end
        check("div_toggle", 32'(div_out), 32'(!prev_div));
      end else begin
        check("div_hold", 32'(div_out), 32'(prev_div));
      end
      prev_div = div_out;
    end
  end

  initial begin
    int t0;
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_max   = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_cur_max", 32'(cur_max), 32'd1);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_pending", 32'(cfg_pending), 32'd0);

    // Default ratio: tick every 2nd cycle
    rst = 1'b0; enable = 1'b1; t0 = cyc;
    push_ticks(t0 + 3, 2, t0 + 11);
    wait_until(t0 + 4);
    check("def_cur_max", 32'(cur_max), 32'd1);
    check("def_ready", 32'(cfg_ready), 32'd1);
    wait_until(t0 + 12); enable = 1'b0;
    wait_until(t0 + 14);

    // cur_max=3, request 5 when counter=1
    apply_cfg(8'd3);
    check("s2_cur_max_init", 32'(cur_max), 32'd3);
    enable = 1'b1; t0 = cyc;
    push_ticks(t0 + 5, 4, t0 + 13);
    push_ticks(t0 + 19, 6, t0 + 31);
    wait_until(t0 + 10); cfg_max = 8'd5; cfg_valid = 1'b1;
    wait_until(t0 + 11); cfg_valid = 1'b0;
    check("s2_pending", 32'(cfg_pending), 32'd1);
    check("s2_ready_low", 32'(cfg_ready), 32'd0);
    check("s2_cur_max_old", 32'(cur_max), 32'd3);
    wait_until(t0 + 12);
    check("s2_pending_hold", 32'(cfg_pending), 32'd1);
    check("s2_ready_hold", 32'(cfg_ready), 32'd0);
    wait_until(t0 + 13);
    check("s2_pending_clr", 32'(cfg_pending), 32'd0);
    check("s2_ready_back", 32'(cfg_ready), 32'd1);
    check("s2_cur_max_new", 32'(cur_max), 32'd5);
    wait_until(t0 + 32); enable = 1'b0;
    wait_until(t0 + 34);

    // Accept coinciding with terminal count: cur_max=2 -> 4
    apply_cfg(8'd2);
    enable = 1'b1; t0 = cyc;
    push_ticks(t0 + 4, 3, t0 + 10);
    push_ticks(t0 + 15, 5, t0 + 20);
    wait_until(t0 + 6); cfg_max = 8'd4; cfg_valid = 1'b1;
    wait_until(t0 + 7); cfg_valid = 1'b0;
    check("s3_pending", 32'(cfg_pending), 32'd1);
    check("s3_cur_max_old", 32'(cur_max), 32'd2);
    wait_until(t0 + 10);
    check("s3_cur_max_new", 32'(cur_max), 32'd4);
    check("s3_pending_clr", 32'(cfg_pending), 32'd0);
    wait_until(t0 + 21); enable = 1'b0;
    wait_until(t0 + 23);

    // cfg_max=0 written in IDLE: tick every cycle
    apply_cfg(8'd0);
    check("s4_cur_max", 32'(cur_max), 32'd0);
    enable = 1'b1; t0 = cyc;
    push_ticks(t0 + 2, 1, t0 + 9);
    wait_until(t0 + 5);
    check("s4_tick_high", 32'(tick), 32'd1);
    wait_until(t0 + 9); enable = 1'b0;
    wait_until(t0 + 11);

    // Drop enable in PEND (old=7, new=2)
    apply_cfg(8'd7);
    enable = 1'b1; t0 = cyc;
    wait_until(t0 + 3); cfg_max = 8'd2; cfg_valid = 1'b1;
    wait_until(t0 + 4); cfg_valid = 1'b0;
    check("s5_pending", 32'(cfg_pending), 32'd1);
    check("s5_ready_low", 32'(cfg_ready), 32'd0);
    wait_until(t0 + 5); enable = 1'b0;
    wait_until(t0 + 6);
    check("s5_cur_max", 32'(cur_max), 32'd2);
    check("s5_pending_clr", 32'(cfg_pending), 32'd0);
    check("s5_ready", 32'(cfg_ready), 32'd1);
    wait_until(t0 + 12);
    enable = 1'b1; t0 = cyc;
    push_ticks(t0 + 4, 3, t0 + 7);
    wait_until(t0 + 8); enable = 1'b0;
    wait_until(t0 + 10);

    // Async reset mid-period with cur_max=9 and a pending value
    apply_cfg(8'd9);
    enable = 1'b1; t0 = cyc;
    wait_until(t0 + 3); cfg_max = 8'd4; cfg_valid = 1'b1;
    wait_until(t0 + 4); cfg_valid = 1'b0;
    check("s6_pending", 32'(cfg_pending), 32'd1);
    wait_until(t0 + 6);
    #2 rst = 1'b1;
    #1;
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_div", 32'(div_out), 32'd0);
    check("arst_cur_max", 32'(cur_max), 32'd1);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    check("arst_pending", 32'(cfg_pending), 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; enable = 1'b1; t0 = cyc;
    push_ticks(t0 + 3, 2, t0 + 7);
    wait_until(t0 + 3);
    check("post_rst_cur_max", 32'(cur_max), 32'd1);
    wait_until(t0 + 8); enable = 1'b0;
    wait_until(t0 + 10);

    // Full-scale ratio: period 2^CNT_W
    apply_cfg(8'hFF);
    check("s7_cur_max", 32'(cur_max), 32'hFF);
    enable = 1'b1; t0 = cyc;
    push_ticks(t0 + 257, 256, t0 + 513);
    wait_until(t0 + 514); enable = 1'b0;
    wait_until(t0 + 516);

    check("tick_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
